// File: rtl/if_id_skid_stage_if.sv
// ============================================================================
// Module   : if_id_skid_stage_if
// Purpose  : Fetch-side and decode-side valid/ready bundle for the IF/ID stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface if_id_skid_stage_if #(
   parameter int PC_W    = 32,
   parameter int INSTR_W = 32
);
   logic               up_valid_i;
   logic               up_ready_o;
   logic [PC_W-1:0]    pc_i;
   logic [INSTR_W-1:0] instr_i;
   logic               dn_valid_o;
   logic               dn_ready_i;
   logic [PC_W-1:0]    pc_o;
   logic [INSTR_W-1:0] instr_o;

   modport slave (
      input  up_valid_i, pc_i, instr_i, dn_ready_i,
      output up_ready_o, dn_valid_o, pc_o, instr_o
   );

   modport master (
      output up_valid_i, pc_i, instr_i, dn_ready_i,
      input  up_ready_o, dn_valid_o, pc_o, instr_o
   );
endinterface

`default_nettype wire

// File: rtl/if_id_skid_stage.sv
// ============================================================================
// Module   : if_id_skid_stage
// Purpose  : IF/ID stage with output slot + skid slot, flush bubble, drop count.
// Revision : 1.0
// ============================================================================
`default_nettype none

module if_id_skid_stage #(
   parameter int                 PC_W         = 32,
   parameter int                 INSTR_W      = 32,
   parameter logic [INSTR_W-1:0] BUBBLE_INSTR = {INSTR_W{1'b0}},
   parameter int                 CNT_W        = 8
) (
   input  wire logic             clk_i,
   input  wire logic             start_i,
   input  wire logic             flush_i,
   if_id_skid_stage_if.slave     bus,
   output logic [1:0]            occupancy_o,
   output logic [CNT_W-1:0]      drop_cnt_o
);

   localparam logic [CNT_W+1:0] c_cnt_max = {2'b00, {CNT_W{1'b1}}};

   logic               r_out_valid;
   logic [PC_W-1:0]    r_out_pc;
   logic [INSTR_W-1:0] r_out_instr;
   logic               r_skid_valid;
   logic [PC_W-1:0]    r_skid_pc;
   logic [INSTR_W-1:0] r_skid_instr;
   logic               r_up_ready;
   logic [1:0]         r_occ;
   logic [CNT_W-1:0]   r_drop;

   logic               w_accept;
   logic               w_consume;
   logic               w_out_free;
   logic               w_out_valid_n;
   logic [PC_W-1:0]    w_out_pc_n;
   logic [INSTR_W-1:0] w_out_instr_n;
   logic               w_skid_valid_n;
   logic [PC_W-1:0]    w_skid_pc_n;
   logic [INSTR_W-1:0] w_skid_instr_n;
   logic [1:0]         w_drop_inc;
   logic [CNT_W+1:0]   w_drop_sum;
   logic [CNT_W-1:0]   w_drop_n;

   assign w_accept   = bus.up_valid_i && r_up_ready;
   assign w_consume  = r_out_valid && bus.dn_ready_i;
   assign w_out_free = !r_out_valid || w_consume;

   always_comb begin
      w_out_valid_n  = r_out_valid;
      w_out_pc_n     = r_out_pc;
      w_out_instr_n  = r_out_instr;
      w_skid_valid_n = r_skid_valid;
      w_skid_pc_n    = r_skid_pc;
      w_skid_instr_n = r_skid_instr;
      w_drop_inc     = 2'd0;

      if (flush_i) begin
         w_out_valid_n  = 1'b0;
         w_out_pc_n     = '0;
         w_out_instr_n  = BUBBLE_INSTR;
         w_skid_valid_n = 1'b0;
         // A beat consumed during the flush still leaves, so it is not a drop.
         w_drop_inc     = {1'b0, r_out_valid && !w_consume}
                        + {1'b0, r_skid_valid}
                        + {1'b0, w_accept};
      end else if (w_out_free) begin
         if (r_skid_valid) begin
            w_out_valid_n  = 1'b1;
            w_out_pc_n     = r_skid_pc;
            w_out_instr_n  = r_skid_instr;
            w_skid_valid_n = w_accept;
            if (w_accept) begin
               w_skid_pc_n    = bus.pc_i;
               w_skid_instr_n = bus.instr_i;
            end
         end else if (w_accept) begin
            w_out_valid_n = 1'b1;
            w_out_pc_n    = bus.pc_i;
            w_out_instr_n = bus.instr_i;
         end else begin
            w_out_valid_n = 1'b0;
            w_out_pc_n    = '0;
            w_out_instr_n = BUBBLE_INSTR;
         end
      end else if (w_accept) begin
         w_skid_valid_n = 1'b1;
         w_skid_pc_n    = bus.pc_i;
         w_skid_instr_n = bus.instr_i;
      end

      w_drop_sum = {2'b00, r_drop} + {{CNT_W{1'b0}}, w_drop_inc};
      w_drop_n   = (w_drop_sum > c_cnt_max) ? {CNT_W{1'b1}} : w_drop_sum[CNT_W-1:0];
   end

   always_ff @(posedge clk_i) begin
      if (!start_i) begin
         r_out_valid  <= 1'b0;
         r_out_pc     <= '0;
         r_out_instr  <= BUBBLE_INSTR;
         r_skid_valid <= 1'b0;
         r_skid_pc    <= '0;
         r_skid_instr <= '0;
         r_up_ready   <= 1'b1;
         r_occ        <= 2'd0;
         r_drop       <= '0;
      end else begin
         r_out_valid  <= w_out_valid_n;
         r_out_pc     <= w_out_pc_n;
         r_out_instr  <= w_out_instr_n;
         r_skid_valid <= w_skid_valid_n;
         r_skid_pc    <= w_skid_pc_n;
         r_skid_instr <= w_skid_instr_n;
         r_up_ready   <= !w_skid_valid_n;
         r_occ        <= {1'b0, w_out_valid_n} + {1'b0, w_skid_valid_n};
         r_drop       <= w_drop_n;
      end
   end

   assign bus.up_ready_o = r_up_ready;
   assign bus.dn_valid_o = r_out_valid;
   assign bus.pc_o       = r_out_pc;
   assign bus.instr_o    = r_out_instr;
   assign occupancy_o    = r_occ;
   assign drop_cnt_o     = r_drop;

endmodule

`default_nettype wire

// File: tb/tb_if_id_skid_stage.sv
// ============================================================================
// Module   : tb_if_id_skid_stage
// Purpose  : Directed self-checking bench for if_id_skid_stage (CNT_W=2).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_if_id_skid_stage;

   localparam logic [31:0] c_bubble = 32'h0000_0013;

   logic       clk = 1'b0;
   logic       start_n;
   logic       flush;
   logic [1:0] occ;
   logic [1:0] drop;

   int n_pass = 0;
   int n_total = 0;

   if_id_skid_stage_if #(.PC_W(32), .INSTR_W(32)) bus ();

   if_id_skid_stage #(
      .PC_W(32), .INSTR_W(32), .BUBBLE_INSTR(c_bubble), .CNT_W(2)
   ) u_dut (
      .clk_i(clk), .start_i(start_n), .flush_i(flush), .bus(bus),
      .occupancy_o(occ), .drop_cnt_o(drop)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] instr_of(input logic [31:0] pc);
      return {16'hCAFE, pc[15:0]};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc);
      bus.up_valid_i = v;
      bus.pc_i       = pc;
      bus.instr_i    = instr_of(pc);
   endtask

   task automatic chk_empty(input string tag);
      chk({tag, "_dnv"}, 64'(bus.dn_valid_o), 64'd0);
      chk({tag, "_pc"}, 64'(bus.pc_o), 64'd0);
      chk({tag, "_instr"}, 64'(bus.instr_o), 64'(c_bubble));
      chk({tag, "_occ"}, 64'(occ), 64'd0);
      chk({tag, "_rdy"}, 64'(bus.up_ready_o), 64'd1);
   endtask

   task automatic chk_out(input string tag, input logic [31:0] pc, input logic [1:0] o, input logic r);
      chk({tag, "_dnv"}, 64'(bus.dn_valid_o), 64'd1);
      chk({tag, "_pc"}, 64'(bus.pc_o), 64'(pc));
      chk({tag, "_instr"}, 64'(bus.instr_o), 64'(instr_of(pc)));
      chk({tag, "_occ"}, 64'(occ), 64'(o));
      chk({tag, "_rdy"}, 64'(bus.up_ready_o), 64'(r));
   endtask

   task automatic do_reset();
      start_n = 1'b0;
      step();
      start_n = 1'b1;
   endtask

   initial begin
      start_n = 1'b0; flush = 1'b0; bus.dn_ready_i = 1'b0;
      drive(1'b1, 32'h100);

      // Reset with fetch valid held high
      step(); step();
      chk_empty("reset");
      chk("reset_drop", 64'(drop), 64'd0);

      // Streaming with decode always ready
      start_n = 1'b1; bus.dn_ready_i = 1'b1;
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 32'(4 * i));
         step();
         chk_out($sformatf("stream%0d", i), 32'(4 * i), 2'd1, 1'b1);
      end
      drive(1'b0, 32'h0);
      step();
      chk_empty("stream_end");

      // Backpressure: fill output then skid, third beat held upstream
      bus.dn_ready_i = 1'b0;
      drive(1'b1, 32'h10); step();
      chk_out("bp_a", 32'h10, 2'd1, 1'b1);
      drive(1'b1, 32'h14); step();
      chk_out("bp_b", 32'h10, 2'd2, 1'b0);
      drive(1'b1, 32'h18); step();
      chk_out("bp_c", 32'h10, 2'd2, 1'b0);
      step();
      chk_out("bp_d", 32'h10, 2'd2, 1'b0);
      bus.dn_ready_i = 1'b1; step();
      chk_out("bp_e", 32'h14, 2'd1, 1'b1);
      step();
      chk_out("bp_f", 32'h18, 2'd1, 1'b1);
      drive(1'b0, 32'h0); step();
      chk_empty("bp_end");
      chk("bp_drop", 64'(drop), 64'd0);

      // Flush while full; the offered beat must never surface
      bus.dn_ready_i = 1'b0;
      drive(1'b1, 32'h20); step();
      drive(1'b1, 32'h24); step();
      chk_out("ff_full", 32'h20, 2'd2, 1'b0);
      drive(1'b1, 32'h28); flush = 1'b1; step();
      flush = 1'b0;
      chk_empty("ff_post");
      chk("ff_drop", 64'(drop), 64'd2);
      drive(1'b0, 32'h0); step();
      chk_empty("ff_after");

      // Flush with consume: output leaves, incoming beat dropped
      do_reset(); #1;
      chk("rst2_drop", 64'(drop), 64'd0);
      bus.dn_ready_i = 1'b1;
      drive(1'b1, 32'h30); step();
      chk_out("fc_a", 32'h30, 2'd1, 1'b1);
      drive(1'b1, 32'h34); flush = 1'b1; step();
      flush = 1'b0;
      chk_empty("fc_post");
      chk("fc_drop", 64'(drop), 64'd1);
      drive(1'b1, 32'h38); step();
      chk_out("fc_next", 32'h38, 2'd1, 1'b1);

      // Counter saturation with CNT_W=2: 2, 3, 3
      drive(1'b0, 32'h0); do_reset();
      bus.dn_ready_i = 1'b0;
      drive(1'b1, 32'h40); step();
      drive(1'b1, 32'h44); step();
      drive(1'b0, 32'h0); flush = 1'b1; step(); flush = 1'b0;
      chk("sat1", 64'(drop), 64'd2);
      drive(1'b1, 32'h48); step();
      chk_out("sat2_fill", 32'h48, 2'd1, 1'b1);
      drive(1'b1, 32'h4C); flush = 1'b1; step(); flush = 1'b0;
      chk("sat2", 64'(drop), 64'd3);
      chk_empty("sat2_post");
      drive(1'b1, 32'h50); step();
      drive(1'b1, 32'h54); step();
      drive(1'b0, 32'h0); flush = 1'b1; step(); flush = 1'b0;
      chk("sat3", 64'(drop), 64'd3);

      // Reset has priority over a simultaneous flush and clears the count
      flush = 1'b1; start_n = 1'b0; step();
      flush = 1'b0; start_n = 1'b1;
      chk("sat_rst", 64'(drop), 64'd0);
      chk_empty("sat_rst");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
